// File: rtl/dcache_sram_nway.sv
// N-way set-associative data cache array with per-set LRU ages and a
// sequential write-back flush engine that streams dirty lines out.
module dcache_sram_nway #(
    parameter int SET_BITS = 4,
    parameter int WAYS     = 2,
    parameter int TAG_BITS = 23,
    parameter int LINE_W   = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [SET_BITS-1:0]   addr_i,
    input  logic [TAG_BITS+1:0]   tag_i,
    input  logic [LINE_W-1:0]     data_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    output logic [TAG_BITS+1:0]   tag_o,
    output logic [LINE_W-1:0]     data_o,
    output logic                  hit_o,
    input  logic                  flush_i,
    output logic                  flush_busy_o,
    output logic                  fl_valid_o,
    input  logic                  fl_ready_i,
    output logic [SET_BITS-1:0]   fl_set_o,
    output logic [TAG_BITS+1:0]   fl_tag_o,
    output logic [LINE_W-1:0]     fl_data_o,
    output logic                  flush_done_o
);
    localparam int SETS      = 1 << SET_BITS;
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int LINES     = SETS * WAYS;
    localparam int LINE_BITS = SET_BITS + WAY_BITS;

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t               state_reg, state_next;
    logic [LINE_BITS-1:0] ptr_reg, ptr_next;

    logic                 valid_arr [LINES];
    logic                 dirty_arr [LINES];
    logic [TAG_BITS-1:0]  tag_arr   [LINES];
    logic [LINE_W-1:0]    data_arr  [LINES];
    logic [WAY_BITS-1:0]  age_arr   [LINES];

    logic                 access, do_write, do_touch, emit_accept, ptr_last;
    logic                 hit_any, found_inv;
    logic [WAY_BITS-1:0]  hit_way, inv_way, old_way, sel_way;
    logic [LINE_BITS-1:0] sel_idx;
    logic [WAY_BITS-1:0]  sel_age;

    // Lines are indexed {set, way}, so the flush pointer walks ways before sets.
    assign access      = enable_i && (state_reg == IDLE) && !rst_i;
    assign do_write    = access && write_i;
    assign do_touch    = access && (write_i || hit_any);
    assign emit_accept = (state_reg == EMIT) && fl_ready_i;
    assign ptr_last    = &ptr_reg;

    always_comb begin
        hit_any   = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        inv_way   = '0;
        old_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_any && valid_arr[{addr_i, WAY_BITS'(w)}]
                && tag_arr[{addr_i, WAY_BITS'(w)}] == tag_i[TAG_BITS-1:0]) begin
                hit_any = 1'b1;
                hit_way = WAY_BITS'(w);
            end
            if (!found_inv && !valid_arr[{addr_i, WAY_BITS'(w)}]) begin
                found_inv = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
            if (age_arr[{addr_i, WAY_BITS'(w)}] == WAY_BITS'(WAYS - 1))
                old_way = WAY_BITS'(w);
        end
    end

    assign sel_way = hit_any ? hit_way : (found_inv ? inv_way : old_way);
    assign sel_idx = {addr_i, sel_way};
    assign sel_age = age_arr[sel_idx];

    assign hit_o  = access && hit_any;
    assign tag_o  = access ? {valid_arr[sel_idx], dirty_arr[sel_idx], tag_arr[sel_idx]} : '0;
    assign data_o = access ? data_arr[sel_idx] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            localparam int SET_OF = gi / WAYS;
            localparam int WAY_OF = gi % WAYS;
            logic                valid_reg, dirty_reg;
            logic [TAG_BITS-1:0] tag_reg;
            logic [LINE_W-1:0]   data_reg;
            logic [WAY_BITS-1:0] age_reg;
            logic                in_set, is_sel;

            assign in_set = (addr_i == SET_BITS'(SET_OF));
            assign is_sel = in_set && (sel_way == WAY_BITS'(WAY_OF));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                    tag_reg   <= '0;
                    data_reg  <= '0;
                    age_reg   <= WAY_BITS'(WAYS - 1 - WAY_OF);
                end else begin
                    if (do_write && is_sel) begin
                        valid_reg <= tag_i[TAG_BITS+1];
                        dirty_reg <= tag_i[TAG_BITS];
                        tag_reg   <= tag_i[TAG_BITS-1:0];
                        data_reg  <= data_i;
                    end else if (emit_accept && ptr_reg == LINE_BITS'(gi)) begin
                        dirty_reg <= 1'b0;
                    end
                    // Younger lines than the touched one age by one; the touched one becomes newest.
                    if (do_touch && in_set) begin
                        if (is_sel)
                            age_reg <= '0;
                        else if (age_reg < sel_age)
                            age_reg <= age_reg + 1'b1;
                    end
                end
            end

            assign valid_arr[gi] = valid_reg;
            assign dirty_arr[gi] = dirty_reg;
            assign tag_arr[gi]   = tag_reg;
            assign data_arr[gi]  = data_reg;
            assign age_arr[gi]   = age_reg;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: if (flush_i) begin
                state_next = SCAN;
                ptr_next   = '0;
            end
            SCAN: if (valid_arr[ptr_reg] && dirty_arr[ptr_reg]) begin
                state_next = EMIT;
            end else begin
                ptr_next = ptr_reg + 1'b1;
                if (ptr_last) state_next = DONE;
            end
            EMIT: if (fl_ready_i) begin
                ptr_next   = ptr_reg + 1'b1;
                state_next = ptr_last ? DONE : SCAN;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        flush_busy_o = (state_reg != IDLE) && !rst_i;
        flush_done_o = (state_reg == DONE) && !rst_i;
        fl_valid_o   = (state_reg == EMIT) && !rst_i;
        fl_set_o     = '0;
        fl_tag_o     = '0;
        fl_data_o    = '0;
        if (fl_valid_o) begin
            fl_set_o  = ptr_reg[LINE_BITS-1:WAY_BITS];
            fl_tag_o  = {valid_arr[ptr_reg], dirty_arr[ptr_reg], tag_arr[ptr_reg]};
            fl_data_o = data_arr[ptr_reg];
        end
    end
endmodule

// File: doc/dcache_sram_nway.md
DCACHE_SRAM_NWAY -- requirements
Module: dcache_sram_nway

Interface
REQ-001 SHALL have parameter SET_BITS, default 4, meaning log2 of the set count (16 sets).
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; a power of two from 2 to 8.
REQ-003 SHALL have parameter TAG_BITS, default 23, meaning address-tag width.
REQ-004 SHALL have parameter LINE_W, default 256, meaning cache-line width in bits.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: addr_i in SET_BITS set index; tag_i in TAG_BITS+2 {valid, dirty, tag}; data_i in LINE_W write line; enable_i in 1 access request; write_i in 1 write qualifier.
REQ-007 SHALL have ports: tag_o out TAG_BITS+2 hit line or victim tag; data_o out LINE_W hit line or victim data; hit_o out 1 hit.
REQ-008 SHALL have ports: flush_i in 1 flush start pulse; flush_busy_o out 1 flush in progress; fl_valid_o out 1 write-back line valid; fl_ready_i in 1 write-back accepted; fl_set_o out SET_BITS; fl_tag_o out TAG_BITS+2; fl_data_o out LINE_W; flush_done_o out 1 one-cycle completion pulse.

Function
REQ-009 Hit (combinational, same cycle): enable_i=1, not flushing, some way with valid=1 and stored tag == tag_i[TAG_BITS-1:0]; hit_o=1, tag_o/data_o = that way.
REQ-010 Miss with enable_i=1: hit_o=0, tag_o/data_o = victim way contents (for write-back); enable_i=0 or flushing: hit_o=0, tag_o=0, data_o=0.
REQ-011 Victim = lowest-index invalid way in the set; if all valid, the way with age WAYS-1.
REQ-012 Write (enable_i=1, write_i=1, rising edge): hit -> overwrite hit way with tag_i/data_i; miss -> overwrite victim way; valid and dirty taken from tag_i.
REQ-013 LRU: per set, per way, a log2(WAYS)-bit age; ages in a set always form a permutation of 0..WAYS-1; 0 = most recent.
REQ-014 On every read hit or write to way w, at the clock edge: ages smaller than age[w] increment, age[w] becomes 0; other sets unchanged; read miss changes no state.
REQ-015 Flush FSM states IDLE, SCAN, EMIT, DONE; flush_busy_o=1 in SCAN/EMIT/DONE.
REQ-016 IDLE: flush_i=1 -> SCAN with pointer set 0, way 0; an access in the same cycle completes normally first.
REQ-017 SCAN: line at pointer valid and dirty -> EMIT; else advance pointer (way first, then set), one line per cycle; after last line -> DONE.
REQ-018 EMIT: fl_valid_o=1 with fl_set_o/fl_tag_o/fl_data_o of pointed line, held stable until fl_ready_i=1; on acceptance clear that line's dirty bit, advance, return to SCAN (or DONE if last).
REQ-019 DONE: flush_done_o=1 for exactly one cycle, then IDLE; flush_i while busy ignored.
REQ-020 During flush enable_i/write_i ignored: no writes, no LRU update; LRU state unchanged by flush.
REQ-021 Empty-set flush (no dirty lines): DONE reached exactly 2^SET_BITS*WAYS cycles after leaving IDLE.

Reset
REQ-022 rst_i=1 at an edge: all tags, data, valid, dirty cleared to 0; ages of way k set to WAYS-1-k; FSM to IDLE, pointer 0.
REQ-023 During and after reset all outputs 0 (hit_o, tag_o, data_o, fl_*, flush_busy_o, flush_done_o); reset mid-flush aborts it with no done pulse.

Verification
REQ-024 WAYS=2: write tag 0x1ABC (valid) data A to set 3, then read same -> hit_o=1, data_o=A, same cycle.
REQ-025 WAYS=4: fill set 5 ways 0..3, read way 1, write new tag -> way 0 replaced; next miss replaces way 2.
REQ-026 Miss on full set whose victim is dirty -> hit_o=0, tag_o shows valid=1, dirty=1, victim tag; data_o victim data.
REQ-027 Three dirty lines (sets 0, 7, 15), fl_ready_i low 4 cycles per line -> three EMIT handshakes in set order, data stable while stalled, dirty bits cleared, one flush_done_o pulse.
REQ-028 rst_i asserted during EMIT -> next cycle flush_busy_o=0, fl_valid_o=0, all reads miss, no flush_done_o.
REQ-029 Access with flush_i in same IDLE cycle -> write lands; accesses during flush give hit_o=0 and modify nothing.
